// File: rtl/mr2rns_horner_seq.sv
// Mixed-radix to RNS converter: Horner evaluation of X = a7, X = X*M_i + a_i,
// carried out in all eight residue lanes at once, one multiply and one reduce per step.
module mr2rns_horner_seq #(
    parameter int DATA_WIDTH = 18,
    parameter int M0 = 262144,
    parameter int M1 = 78125,
    parameter int M2 = 117649,
    parameter int M3 = 177147,
    parameter int M4 = 262027,
    parameter int M5 = 262049,
    parameter int M6 = 262051,
    parameter int M7 = 262069
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] Dig_in_0,
    input  logic [DATA_WIDTH-1:0] Dig_in_1,
    input  logic [DATA_WIDTH-1:0] Dig_in_2,
    input  logic [DATA_WIDTH-1:0] Dig_in_3,
    input  logic [DATA_WIDTH-1:0] Dig_in_4,
    input  logic [DATA_WIDTH-1:0] Dig_in_5,
    input  logic [DATA_WIDTH-1:0] Dig_in_6,
    input  logic [DATA_WIDTH-1:0] Dig_in_7,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Res_out_0,
    output logic [DATA_WIDTH-1:0] Res_out_1,
    output logic [DATA_WIDTH-1:0] Res_out_2,
    output logic [DATA_WIDTH-1:0] Res_out_3,
    output logic [DATA_WIDTH-1:0] Res_out_4,
    output logic [DATA_WIDTH-1:0] Res_out_5,
    output logic [DATA_WIDTH-1:0] Res_out_6,
    output logic [DATA_WIDTH-1:0] Res_out_7,
    output logic                  out_err
);

    localparam int DW = DATA_WIDTH;
    localparam int MW = DATA_WIDTH + 1;
    localparam int PW = 2 * DATA_WIDTH;

    // Moduli need one extra bit: M0 = 2^18 does not fit in a digit-wide word.
    localparam logic [MW-1:0] MODS [8] = '{
        MW'(M0), MW'(M1), MW'(M2), MW'(M3),
        MW'(M4), MW'(M5), MW'(M6), MW'(M7)
    };

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        RED,
        DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [2:0]    step_q;
    logic [DW-1:0] dig_in [8];
    logic [DW-1:0] dig_q  [8];
    logic [DW-1:0] acc_q  [8];
    logic [PW-1:0] prod_q [8];
    logic [PW-1:0] mod_ext;
    logic          range_err;
    logic          err_pend_q;
    logic          err_q;
    logic          accept;

    assign dig_in[0] = Dig_in_0;
    assign dig_in[1] = Dig_in_1;
    assign dig_in[2] = Dig_in_2;
    assign dig_in[3] = Dig_in_3;
    assign dig_in[4] = Dig_in_4;
    assign dig_in[5] = Dig_in_5;
    assign dig_in[6] = Dig_in_6;
    assign dig_in[7] = Dig_in_7;

    always_comb begin
        range_err = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if ({1'b0, dig_in[k]} >= MODS[k]) begin
                range_err = 1'b1;
            end
        end
    end

    assign mod_ext = PW'(MODS[step_q]);
    assign accept  = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: state_d = MUL;
            MUL:  state_d = RED;
            RED: begin
                if (step_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = MUL;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The accumulators double as the output registers, so they stay put in IDLE/DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q     <= 3'd0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
            for (int j = 0; j < 8; j++) begin
                dig_q[j]  <= '0;
                acc_q[j]  <= '0;
                prod_q[j] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        step_q     <= 3'd6;
                        err_pend_q <= range_err;
                        for (int j = 0; j < 8; j++) begin
                            dig_q[j] <= dig_in[j];
                        end
                    end
                end
                LOAD: begin
                    err_q <= err_pend_q;
                    for (int j = 0; j < 8; j++) begin
                        acc_q[j] <= DW'({1'b0, dig_q[7]} % MODS[j]);
                    end
                end
                MUL: begin
                    for (int j = 0; j < 8; j++) begin
                        prod_q[j] <= PW'(acc_q[j]) * mod_ext;
                    end
                end
                RED: begin
                    for (int j = 0; j < 8; j++) begin
                        acc_q[j] <= DW'(({1'b0, prod_q[j]} + (PW + 1)'(dig_q[step_q]))
                                        % (PW + 1)'(MODS[j]));
                    end
                    if (step_q != 3'd0) begin
                        step_q <= step_q - 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Res_out_0 = acc_q[0];
    assign Res_out_1 = acc_q[1];
    assign Res_out_2 = acc_q[2];
    assign Res_out_3 = acc_q[3];
    assign Res_out_4 = acc_q[4];
    assign Res_out_5 = acc_q[5];
    assign Res_out_6 = acc_q[6];
    assign Res_out_7 = acc_q[7];
    assign out_err   = err_q;

endmodule

// File: tb/tb_mr2rns_horner_seq.sv
// Directed bench for mr2rns_horner_seq: hand-computed residues, latency,
// backpressure, range error and mid-conversion reset.
module tb_mr2rns_horner_seq;

    localparam int MODS [8] = '{262144, 78125, 117649, 177147, 262027, 262049, 262051, 262069};
    localparam int EXP_A1 [8] = '{0, 27769, 26846, 84997, 117, 95, 93, 75};

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] dig [8];
    logic        out_valid;
    logic        out_ready;
    logic [17:0] res [8];
    logic        out_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mr2rns_horner_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Dig_in_0  (dig[0]),
        .Dig_in_1  (dig[1]),
        .Dig_in_2  (dig[2]),
        .Dig_in_3  (dig[3]),
        .Dig_in_4  (dig[4]),
        .Dig_in_5  (dig[5]),
        .Dig_in_6  (dig[6]),
        .Dig_in_7  (dig[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Res_out_0 (res[0]),
        .Res_out_1 (res[1]),
        .Res_out_2 (res[2]),
        .Res_out_3 (res[3]),
        .Res_out_4 (res[4]),
        .Res_out_5 (res[5]),
        .Res_out_6 (res[6]),
        .Res_out_7 (res[7]),
        .out_err   (out_err)
    );

    task automatic set_digits(input int v0, input int v1, input int v2, input int v3,
                              input int v4, input int v5, input int v6, input int v7);
        dig[0] = 18'(v0); dig[1] = 18'(v1); dig[2] = 18'(v2); dig[3] = 18'(v3);
        dig[4] = 18'(v4); dig[5] = 18'(v5); dig[6] = 18'(v6); dig[7] = 18'(v7);
    endtask

    // Handshake at the next edge; lat = edges from handshake to out_valid, -1 on timeout.
    task automatic run_conv(output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic take_output();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        set_digits(5, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        total++;
        if (out_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_err got=%b want=0", out_err); end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (res[j] !== 18'd0) begin bad++; $display("[TB] FAIL reset_res%0d got=%0d want=0", j, res[j]); end
        end
    endtask

    task automatic test_zero();
        int lat;
        set_digits(0, 0, 0, 0, 0, 0, 0, 0);
        run_conv(lat);
        total++;
        if (lat !== 15) begin bad++; $display("[TB] FAIL zero_latency got=%0d want=15", lat); end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (res[j] !== 18'd0) begin bad++; $display("[TB] FAIL zero_res%0d got=%0d want=0", j, res[j]); end
        end
        total++;
        if (out_err !== 1'b0) begin bad++; $display("[TB] FAIL zero_err got=%b want=0", out_err); end
        take_output();
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL zero_ready_after got=%b want=1", in_ready); end
    endtask

    task automatic test_a0();
        int lat;
        set_digits(5, 0, 0, 0, 0, 0, 0, 0);
        run_conv(lat);
        total++;
        if (lat !== 15) begin bad++; $display("[TB] FAIL a0_latency got=%0d want=15", lat); end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (res[j] !== 18'd5) begin bad++; $display("[TB] FAIL a0_res%0d got=%0d want=5", j, res[j]); end
        end
        take_output();
    endtask

    task automatic test_a1();
        int lat;
        set_digits(0, 1, 0, 0, 0, 0, 0, 0);
        run_conv(lat);
        total++;
        if (lat !== 15) begin bad++; $display("[TB] FAIL a1_latency got=%0d want=15", lat); end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (res[j] !== 18'(EXP_A1[j])) begin
                bad++; $display("[TB] FAIL a1_res%0d got=%0d want=%0d", j, res[j], EXP_A1[j]);
            end
        end
        take_output();
    endtask

    task automatic test_max();
        int lat;
        set_digits(MODS[0] - 1, MODS[1] - 1, MODS[2] - 1, MODS[3] - 1,
                   MODS[4] - 1, MODS[5] - 1, MODS[6] - 1, MODS[7] - 1);
        run_conv(lat);
        total++;
        if (lat !== 15) begin bad++; $display("[TB] FAIL max_latency got=%0d want=15", lat); end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (res[j] !== 18'(MODS[j] - 1)) begin
                bad++; $display("[TB] FAIL max_res%0d got=%0d want=%0d", j, res[j], MODS[j] - 1);
            end
        end
        total++;
        if (out_err !== 1'b0) begin bad++; $display("[TB] FAIL max_err got=%b want=0", out_err); end
        take_output();
    endtask

    task automatic test_backpressure();
        int lat;
        set_digits(0, 1, 0, 0, 0, 0, 0, 0);
        run_conv(lat);
        total++;
        if (lat !== 15) begin bad++; $display("[TB] FAIL bp_latency got=%0d want=15", lat); end
        set_digits(5, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid c%0d got=%b want=1", c, out_valid); end
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready c%0d got=%b want=0", c, in_ready); end
            for (int j = 0; j < 8; j++) begin
                total++;
                if (res[j] !== 18'(EXP_A1[j])) begin
                    bad++; $display("[TB] FAIL bp_res%0d c%0d got=%0d want=%0d", j, c, res[j], EXP_A1[j]);
                end
            end
        end
        in_valid = 1'b1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_done_ready got=%b want=0", in_ready); end
        take_output();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_ready_after got=%b want=1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_valid_after got=%b want=0", out_valid); end
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_no_accept got=%b want=1", in_ready); end
    endtask

    task automatic test_err();
        int lat;
        set_digits(0, 78125, 0, 0, 0, 0, 0, 0);
        run_conv(lat);
        total++;
        if (lat !== 15) begin bad++; $display("[TB] FAIL err_latency got=%0d want=15", lat); end
        total++;
        if (out_err !== 1'b1) begin bad++; $display("[TB] FAIL err_flag got=%b want=1", out_err); end
        take_output();
    endtask

    task automatic test_mid_reset();
        int lat;
        set_digits(0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_in_ready got=%b want=1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_out_valid got=%b want=0", out_valid); end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (res[j] !== 18'd0) begin bad++; $display("[TB] FAIL mid_res%0d got=%0d want=0", j, res[j]); end
        end
        set_digits(5, 0, 0, 0, 0, 0, 0, 0);
        run_conv(lat);
        total++;
        if (lat !== 15) begin bad++; $display("[TB] FAIL mid_latency got=%0d want=15", lat); end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (res[j] !== 18'd5) begin bad++; $display("[TB] FAIL mid_res_after%0d got=%0d want=5", j, res[j]); end
        end
        take_output();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_a0();
        test_a1();
        test_max();
        test_backpressure();
        test_err();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
